// File: rtl/alu_if.sv
// alu_if: operand/result bundle for the alu datapath element.
//   a, b       : WIDTH-bit operands (driven by master)
//   operation  : 2-bit op select, 0=ADD 1=SUB 2=AND 3=OR (driven by master)
//   result     : WIDTH-bit registered result (driven by slave)
//   carry, zero, negative, overflow : registered status flags (driven by slave)
interface alu_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       operation;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             negative;
  logic             overflow;

  modport master (
    output a, b, operation,
    input  result, carry, zero, negative, overflow
  );

  modport slave (
    input  a, b, operation,
    output result, carry, zero, negative, overflow
  );
endinterface

// File: rtl/alu.sv
// alu: four-function integer ALU (add, sub, and, or) with registered
// result and flags, one cycle latency, full throughput.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears result and all flags
//   bus  : alu_if slave port (operands/op in, result/flags out)
module alu #(
  parameter int WIDTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] res_nxt;
  logic             carry_nxt;
  logic             ovf_nxt;

  // Zero-extended arithmetic: the extra top bit is the carry-out for add
  // and the borrow (a < b unsigned) for subtract.
  assign sum_ext  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff_ext = {1'b0, bus.a} - {1'b0, bus.b};

  always_comb begin
    res_nxt   = '0;
    carry_nxt = 1'b0;
    ovf_nxt   = 1'b0;
    unique case (bus.operation)
      2'd0: begin
        res_nxt   = sum_ext[WIDTH-1:0];
        carry_nxt = sum_ext[WIDTH];
        ovf_nxt   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                    (sum_ext[WIDTH-1] != bus.a[WIDTH-1]);
      end
      2'd1: begin
        res_nxt   = diff_ext[WIDTH-1:0];
        carry_nxt = diff_ext[WIDTH];
        ovf_nxt   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                    (diff_ext[WIDTH-1] != bus.a[WIDTH-1]);
      end
      2'd2: res_nxt = bus.a & bus.b;
      2'd3: res_nxt = bus.a | bus.b;
      default: res_nxt = '0;
    endcase
  end

  // Zero flag is forced low in reset even though result is 0 there.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result   <= '0;
      bus.carry    <= 1'b0;
      bus.zero     <= 1'b0;
      bus.negative <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.result   <= res_nxt;
      bus.carry    <= carry_nxt;
      bus.zero     <= (res_nxt == '0);
      bus.negative <= res_nxt[WIDTH-1];
      bus.overflow <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_alu.sv
module tb_alu;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [3:0] exp_res;
  logic       exp_c, exp_z, exp_n, exp_v;

  alu_if #(.WIDTH(4)) bus ();

  alu #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input int a, input int b, input int op, input bit r);
    int sa, sb, t, sv, res;
    bit c, v;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    c = 0; v = 0; res = 0;
    case (op)
      0: begin t = a + b; res = t % 16; c = (t >= 16); sv = sa + sb; v = (sv > 7 || sv < -8); end
      1: begin t = a - b; res = (t + 16) % 16; c = (a < b); sv = sa - sb; v = (sv > 7 || sv < -8); end
      2: res = a & b;
      default: res = a | b;
    endcase
    if (r) begin
      exp_res = 4'd0; exp_c = 0; exp_z = 0; exp_n = 0; exp_v = 0;
    end else begin
      exp_res = 4'(res); exp_c = c; exp_z = (res == 0); exp_n = (res >= 8); exp_v = v;
    end
  endfunction

  task automatic check_all(input string tag);
    checks++;
    assert (bus.result === exp_res) else begin
      errors++; $error("FAIL %s.result got=%0d exp=%0d", tag, bus.result, exp_res);
    end
    checks++;
    assert (bus.carry === exp_c) else begin
      errors++; $error("FAIL %s.carry got=%0b exp=%0b", tag, bus.carry, exp_c);
    end
    checks++;
    assert (bus.zero === exp_z) else begin
      errors++; $error("FAIL %s.zero got=%0b exp=%0b", tag, bus.zero, exp_z);
    end
    checks++;
    assert (bus.negative === exp_n) else begin
      errors++; $error("FAIL %s.negative got=%0b exp=%0b", tag, bus.negative, exp_n);
    end
    checks++;
    assert (bus.overflow === exp_v) else begin
      errors++; $error("FAIL %s.overflow got=%0b exp=%0b", tag, bus.overflow, exp_v);
    end
  endtask

  // Apply inputs, take one edge, check; then disturb inputs mid-cycle and
  // confirm the registered outputs do not move.
  task automatic step(input bit r, input int a, input int b, input int op, input string tag);
    rst = r;
    bus.a = 4'(a);
    bus.b = 4'(b);
    bus.operation = 2'(op);
    @(posedge clk);
    #1;
    model(a, b, op, r);
    check_all(tag);
    bus.a = 4'($urandom);
    bus.b = 4'($urandom);
    bus.operation = 2'($urandom);
    #2;
    check_all({tag, "_hold"});
  endtask

  initial begin
    rst = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.operation = '0;

    step(1, 3, 2, 0, "rst0");
    step(1, 3, 2, 0, "rst1");
    step(0, 3, 2, 0, "post_rst");

    for (int op = 0; op < 4; op++) step(0, 3, 2, op, "sweep");

    step(0, 15, 1, 0, "add_wrap");
    step(0, 2, 3, 1, "sub_borrow");
    step(0, 7, 1, 0, "add_ovf");
    step(0, 8, 1, 1, "sub_ovf");
    step(0, 10, 5, 2, "and_zero");
    step(0, 10, 5, 3, "or_neg");
    step(0, 8, 8, 0, "add_neg_ovf");
    step(0, 0, 0, 1, "sub_zero");

    for (int i = 0; i < 8; i++)
      step(i == 4, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 3)), "b2b");

    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 19) == 0), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
